// File: rtl/key_autorepeat.sv
// Turns a debounced key level into single-cycle action pulses, with a slow
// then fast auto-repeat while the key is held, and a pulse on release.
module key_autorepeat #(
    parameter int HOLD_CYCLES   = 25_000_000,
    parameter int REPEAT_CYCLES = 5_000_000,
    parameter int FAST_AFTER    = 8,
    parameter int FAST_CYCLES   = 1_250_000,
    parameter int CNT_W         = 25
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_i,
    output logic pulse_o,
    output logic repeating_o,
    output logic release_o
);

    localparam int RC_W = (FAST_AFTER < 2) ? 1 : $clog2(FAST_AFTER + 1);

    localparam logic [CNT_W-1:0] HOLD_T   = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] REPEAT_T = CNT_W'(REPEAT_CYCLES);
    localparam logic [CNT_W-1:0] FAST_T   = CNT_W'(FAST_CYCLES);
    localparam logic [RC_W-1:0]  FA_CNT   = RC_W'(FAST_AFTER);

    typedef enum logic [1:0] {IDLE, HOLD, SLOW, FAST} state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_timer;
    logic [RC_W-1:0]   r_rcnt;
    logic              r_key_q;

    logic w_press;
    logic w_release;

    assign w_press   = key_i & ~r_key_q;
    assign w_release = ~key_i & r_key_q;

    // key_q resets high so a key held through reset must be released before
    // it can produce a press.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_timer     <= '0;
            r_rcnt      <= '0;
            r_key_q     <= 1'b1;
            pulse_o     <= 1'b0;
            repeating_o <= 1'b0;
            release_o   <= 1'b0;
        end else begin
            r_key_q   <= key_i;
            pulse_o   <= 1'b0;
            release_o <= 1'b0;
            if (r_state == IDLE) begin
                if (w_press) begin
                    pulse_o <= 1'b1;
                    r_timer <= CNT_W'(1);
                    r_state <= HOLD;
                end
            end else if (w_release) begin
                // Release wins over a timer expiry in the same cycle.
                release_o   <= 1'b1;
                r_timer     <= '0;
                r_rcnt      <= '0;
                repeating_o <= 1'b0;
                r_state     <= IDLE;
            end else begin
                case (r_state)
                    HOLD: begin
                        if (r_timer == HOLD_T) begin
                            pulse_o     <= 1'b1;
                            r_timer     <= CNT_W'(1);
                            r_rcnt      <= RC_W'(1);
                            repeating_o <= 1'b1;
                            r_state     <= (FAST_AFTER == 1) ? FAST : SLOW;
                        end else begin
                            r_timer <= r_timer + 1'b1;
                        end
                    end
                    SLOW: begin
                        if (r_timer == REPEAT_T) begin
                            pulse_o <= 1'b1;
                            r_timer <= CNT_W'(1);
                            // Count saturates; the expiry that finds it full
                            // is the last slow interval.
                            if (r_rcnt >= FA_CNT)
                                r_state <= FAST;
                            else
                                r_rcnt <= r_rcnt + 1'b1;
                        end else begin
                            r_timer <= r_timer + 1'b1;
                        end
                    end
                    FAST: begin
                        if (r_timer == FAST_T) begin
                            pulse_o <= 1'b1;
                            r_timer <= CNT_W'(1);
                        end else begin
                            r_timer <= r_timer + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
